keypad_scanner_p: RTL and testbench

- Parametrised matrix-keypad scanner; next generation of the lock's fixed 4x3 scanner.
- Drives one-hot column strobes and reads the row returns through an internal synchroniser.
- Debounces press and release, rejects multi-key presses, and optionally auto-repeats.
- Delivers a registered key index plus a one-cycle valid pulse to the lock controller.

---
 rtl/keypad_scanner_p_if.sv | 16 +
 rtl/keypad_scanner_p.sv | 157 +++++++++++++++
 tb/tb_keypad_scanner_p.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_p_if.sv
// Keypad scanner bus: row returns in, column strobes and key events out.
interface keypad_scanner_p_if #(
  parameter int NUM_ROWS = 4,
  parameter int NUM_COLS = 3,
  parameter int CODE_W   = $clog2(NUM_ROWS*NUM_COLS)
);
  logic [NUM_ROWS-1:0] row;
  logic [NUM_COLS-1:0] col;
  logic [CODE_W-1:0]   key_code;
  logic                key_valid;
  logic                key_held;
  logic                multi_key;

  modport master (output row, input col, key_code, key_valid, key_held, multi_key);
  modport slave  (input row, output col, key_code, key_valid, key_held, multi_key);
endinterface

// File: rtl/keypad_scanner_p.sv
// Parametrised matrix-keypad scanner: column strobing, synchronised row sampling,
// press/release debounce, multi-key lockout and optional auto-repeat.
module keypad_scanner_p #(
  parameter int NUM_ROWS        = 4,
  parameter int NUM_COLS        = 3,
  parameter int SCAN_DWELL      = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 0
) (
  input logic          clock,
  input logic          reset,
  keypad_scanner_p_if.slave kp
);
  localparam int CODE_W = $clog2(NUM_ROWS*NUM_COLS);
  localparam int RI_W   = $clog2(NUM_ROWS);
  localparam int CI_W   = $clog2(NUM_COLS);
  localparam int DW_W   = $clog2(SCAN_DWELL+1);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES+1);
  localparam int RP_W   = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [DW_W-1:0]     DWELL_LAST = DW_W'(SCAN_DWELL);
  localparam logic [DB_W-1:0]     DB_LAST    = DB_W'(DEBOUNCE_CYCLES-1);
  localparam logic [RP_W-1:0]     RP_LAST    = RP_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES-1 : 0);
  localparam logic [CI_W-1:0]     COL_LAST   = CI_W'(NUM_COLS-1);
  localparam logic [NUM_COLS-1:0] ALL_COLS   = '1;
  localparam logic [NUM_COLS-1:0] FIRST_COL  = NUM_COLS'(1);

  typedef enum logic [2:0] {IDLE, SCAN, DEBOUNCE, HELD, LOCKOUT} state_t;

  state_t              state;
  logic [NUM_ROWS-1:0] row_m, row_s, pattern;
  logic [NUM_COLS-1:0] col_q;
  logic [CI_W-1:0]     col_idx;
  logic [RI_W-1:0]     row_idx, hit_idx;
  logic [DW_W-1:0]     dwell;
  logic [DB_W-1:0]     cnt;
  logic [RP_W-1:0]     rep_cnt;
  logic [CODE_W-1:0]   key_code;
  logic                key_valid, key_held, multi_key;
  logic                any_row, multi, one_hot;

  assign kp.col       = col_q;
  assign kp.key_code  = key_code;
  assign kp.key_valid = key_valid;
  assign kp.key_held  = key_held;
  assign kp.multi_key = multi_key;

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      row_m <= '0;
      row_s <= '0;
    end else begin
      row_m <= kp.row;
      row_s <= row_m;
    end

  // x & (x-1) clears the lowest set bit: non-zero means two or more rows.
  assign any_row = |row_s;
  assign multi   = (row_s & (row_s - NUM_ROWS'(1))) != '0;
  assign one_hot = any_row && !multi;

  always_comb begin
    hit_idx = '0;
    for (int r = 0; r < NUM_ROWS; r++)
      if (row_s[r]) hit_idx = RI_W'(r);
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      col_q     <= ALL_COLS;
      col_idx   <= '0;
      row_idx   <= '0;
      pattern   <= '0;
      dwell     <= '0;
      cnt       <= '0;
      rep_cnt   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      multi_key <= 1'b0;
      case (state)
        IDLE: begin
          col_q <= ALL_COLS;
          if (any_row) begin
            state   <= SCAN;
            col_idx <= '0;
            dwell   <= '0;
            col_q   <= FIRST_COL;
          end
        end
        // Only the end-of-dwell sample counts; the dwell hides synchroniser lag.
        SCAN: begin
          if (dwell != DWELL_LAST) dwell <= dwell + DW_W'(1);
          else begin
            dwell <= '0;
            if (one_hot) begin
              state   <= DEBOUNCE;
              row_idx <= hit_idx;
              pattern <= row_s;
              cnt     <= '0;
            end else if (multi) begin
              multi_key <= 1'b1;
              state     <= LOCKOUT;
              col_q     <= ALL_COLS;
              cnt       <= '0;
            end else if (col_idx != COL_LAST) begin
              col_idx <= col_idx + CI_W'(1);
              col_q   <= col_q << 1;
            end else begin
              state <= IDLE;
              col_q <= ALL_COLS;
            end
          end
        end
        DEBOUNCE: begin
          if (row_s != pattern) begin
            state <= IDLE;
            col_q <= ALL_COLS;
          end else if (cnt == DB_LAST) begin
            key_code  <= CODE_W'(row_idx) * CODE_W'(NUM_COLS) + CODE_W'(col_idx);
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= HELD;
            cnt       <= '0;
            rep_cnt   <= '0;
          end else cnt <= cnt + DB_W'(1);
        end
        // Repeat counter freezes while a release is being counted.
        HELD: begin
          if (row_s[row_idx]) begin
            cnt <= '0;
            if (REPEAT_CYCLES > 0) begin
              if (rep_cnt == RP_LAST) begin
                rep_cnt   <= '0;
                key_valid <= 1'b1;
              end else rep_cnt <= rep_cnt + RP_W'(1);
            end
          end else if (cnt == DB_LAST) begin
            key_held <= 1'b0;
            state    <= IDLE;
            col_q    <= ALL_COLS;
          end else cnt <= cnt + DB_W'(1);
        end
        LOCKOUT: begin
          col_q <= ALL_COLS;
          if (any_row)              cnt   <= '0;
          else if (cnt == DB_LAST)  state <= IDLE;
          else                      cnt   <= cnt + DB_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_keypad_scanner_p.sv
// Directed bench: a 4x3 default scanner and an 8x8 auto-repeat scanner, each fed by a keypad matrix model.
module tb_keypad_scanner_p;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  keypad_scanner_p_if #(.NUM_ROWS(4), .NUM_COLS(3)) kp0 ();
  keypad_scanner_p_if #(.NUM_ROWS(8), .NUM_COLS(8)) kp8 ();

  keypad_scanner_p #(.NUM_ROWS(4), .NUM_COLS(3), .SCAN_DWELL(4), .DEBOUNCE_CYCLES(16),
                     .REPEAT_CYCLES(0)) dut0 (.clock(clock), .reset(reset), .kp(kp0.slave));
  keypad_scanner_p #(.NUM_ROWS(8), .NUM_COLS(8), .SCAN_DWELL(4), .DEBOUNCE_CYCLES(16),
                     .REPEAT_CYCLES(50)) dut8 (.clock(clock), .reset(reset), .kp(kp8.slave));

  // Pressed key (r,c) connects column strobe c to row return r.
  logic [3:0][2:0] keys0;
  logic [3:0]      glitch0;
  logic [7:0][7:0] keys8;

  always_comb begin
    kp0.row = '0;
    for (int r = 0; r < 4; r++) kp0.row[r] = (|(keys0[r] & kp0.col)) | glitch0[r];
  end
  always_comb begin
    kp8.row = '0;
    for (int r = 0; r < 8; r++) kp8.row[r] = |(keys8[r] & kp8.col);
  end

  int ncmp = 0, nerr = 0;
  int v0 = 0, m0 = 0, v8 = 0, cyc = 0;
  int v8_t[$];
  logic [3:0] prev_code0;
  logic [5:0] prev_code8;
  logic       prev_rst = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    cyc++;
    if (kp0.key_valid) v0++;
    if (kp0.multi_key) m0++;
    if (kp8.key_valid) begin v8++; v8_t.push_back(cyc); end
    if (reset) begin
      chk("valid_multi_excl0", int'(kp0.key_valid & kp0.multi_key), 0);
      if (prev_rst && !kp0.key_valid) chk("code_stable0", int'(kp0.key_code), int'(prev_code0));
      if (prev_rst && !kp8.key_valid) chk("code_stable8", int'(kp8.key_code), int'(prev_code8));
    end
    prev_code0 = kp0.key_code;
    prev_code8 = kp8.key_code;
    prev_rst   = reset;
  end

  initial begin
    int w, base, mb;
    logic [2:0] seen;
    keys0 = '0; glitch0 = '0; keys8 = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_col0", int'(kp0.col), 7);
    chk("rst_code0", int'(kp0.key_code), 0);
    chk("rst_valid0", int'(kp0.key_valid), 0);
    chk("rst_held0", int'(kp0.key_held), 0);
    chk("rst_multi0", int'(kp0.multi_key), 0);
    chk("rst_col8", int'(kp8.col), 255);
    reset = 1'b1;
    repeat (2) tick();

    // Single press of key (1,2), long hold, release
    keys0[1][2] = 1'b1;
    w = 0;
    while (v0 < 1 && w < 60) begin tick(); w++; end
    chk("press_valid", v0, 1);
    chk("press_latency_le34", int'(w <= 34), 1);
    chk("press_code", int'(kp0.key_code), 5);
    chk("press_held", int'(kp0.key_held), 1);
    repeat (200) tick();
    chk("hold_no_repeat", v0, 1);
    chk("hold_held", int'(kp0.key_held), 1);
    chk("hold_col", int'(kp0.col), 4);
    keys0 = '0;
    repeat (20) tick();
    chk("release_held", int'(kp0.key_held), 0);
    chk("release_col", int'(kp0.col), 7);
    chk("release_no_pulse", v0, 1);

    // Bouncing key (0,0), then stable
    base = v0;
    for (int i = 0; i < 20; i++) begin
      keys0[0][0] = (i % 2 == 0);
      repeat (5) tick();
    end
    chk("bounce_no_valid", v0, base);
    chk("bounce_no_multi", m0, 0);
    keys0[0][0] = 1'b1;
    w = 0;
    while (v0 < base + 1 && w < 80) begin tick(); w++; end
    chk("bounce_valid", v0, base + 1);
    chk("bounce_code", int'(kp0.key_code), 0);
    repeat (40) tick();
    chk("bounce_single", v0, base + 1);
    keys0 = '0;
    repeat (25) tick();
    chk("bounce_release", int'(kp0.key_held), 0);

    // Two keys in column 1 -> lockout
    base = v0; mb = m0;
    keys0[0][1] = 1'b1; keys0[1][1] = 1'b1;
    w = 0;
    while (m0 < mb + 1 && w < 60) begin tick(); w++; end
    chk("multi_pulse", m0, mb + 1);
    chk("multi_code_kept", int'(kp0.key_code), 0);
    repeat (50) tick();
    chk("multi_once", m0, mb + 1);
    chk("multi_col", int'(kp0.col), 7);
    chk("multi_no_valid", v0, base);
    keys0 = '0;
    repeat (10) tick();
    keys0[0][1] = 1'b1; keys0[1][1] = 1'b1;
    repeat (40) tick();
    chk("lockout_short_gap", m0, mb + 1);
    chk("lockout_col", int'(kp0.col), 7);
    keys0 = '0;
    repeat (20) tick();
    chk("lockout_exit_col", int'(kp0.col), 7);
    keys0[2][0] = 1'b1;
    w = 0;
    while (v0 < base + 1 && w < 60) begin tick(); w++; end
    chk("after_lockout_valid", v0, base + 1);
    chk("after_lockout_code", int'(kp0.key_code), 6);
    keys0 = '0;
    repeat (25) tick();

    // Spurious 3-cycle wake on row 3
    base = v0; mb = m0; seen = '0;
    glitch0[3] = 1'b1;
    repeat (3) begin tick(); if (kp0.col != 3'b111) seen |= kp0.col; end
    glitch0 = '0;
    repeat (40) begin tick(); if (kp0.col != 3'b111) seen |= kp0.col; end
    chk("spur_full_scan", int'(seen), 7);
    chk("spur_idle_col", int'(kp0.col), 7);
    chk("spur_no_valid", v0, base);
    chk("spur_no_multi", m0, mb);
    chk("spur_no_held", int'(kp0.key_held), 0);

    // Reset while HELD, key kept down across deassertion
    base = v0;
    keys0[1][2] = 1'b1;
    w = 0;
    while (v0 < base + 1 && w < 60) begin tick(); w++; end
    chk("pre_reset_held", int'(kp0.key_held), 1);
    tick();
    reset = 1'b0;
    #1;
    chk("async_rst_col", int'(kp0.col), 7);
    chk("async_rst_held", int'(kp0.key_held), 0);
    chk("async_rst_code", int'(kp0.key_code), 0);
    chk("async_rst_valid", int'(kp0.key_valid), 0);
    repeat (3) tick();
    reset = 1'b1;
    base = v0;
    w = 0;
    while (v0 < base + 1 && w < 60) begin tick(); w++; end
    chk("post_rst_valid", v0, base + 1);
    chk("post_rst_debounced", int'(w >= 17), 1);
    chk("post_rst_code", int'(kp0.key_code), 5);
    repeat (100) tick();
    chk("post_rst_single", v0, base + 1);
    keys0 = '0;
    repeat (25) tick();

    // 8x8 auto-repeat on key (7,7)
    keys8[7][7] = 1'b1;
    w = 0;
    while (v8 < 1 && w < 70) begin tick(); w++; end
    chk("rep_first_valid", v8, 1);
    chk("rep_latency_le59", int'(w <= 59), 1);
    chk("rep_code", int'(kp8.key_code), 63);
    repeat (275) tick();
    keys8 = '0;
    repeat (40) tick();
    chk("rep_count", v8, 6);
    chk("rep_gap_first", (v8_t.size() >= 2) ? v8_t[1] - v8_t[0] : -1, 50);
    chk("rep_gap_last", (v8_t.size() >= 6) ? v8_t[5] - v8_t[4] : -1, 50);
    chk("rep_release_held", int'(kp8.key_held), 0);
    chk("code_kept0", int'(kp0.key_code), 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
